// File: rtl/fetch_align_pkg.sv
// Shared pipeline-register types for the IF/ID boundary.
// Also holds parcel helpers used by the fetch/align stage.
package PipelineReg;

    localparam int PARCEL_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } ID_STATE;

    function automatic logic is_rvc(input logic [PARCEL_W-1:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_align_buf.sv
// Four-entry 16-bit parcel FIFO for the fetch/align stage.
// Parcels pushed this cycle are visible at the head in the same cycle.
module parcel_buf
    import PipelineReg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [1:0]            push_n,
    input  logic [2*PARCEL_W-1:0] push_data,
    input  logic [1:0]            pop_n,
    output logic [2*PARCEL_W-1:0] head,
    output logic [2:0]            count
);

    logic [4*PARCEL_W-1:0] buf_q;
    logic [6*PARCEL_W-1:0] merged;
    logic [6*PARCEL_W-1:0] shifted;
    logic [2:0]            avail;

    assign avail = count + {1'b0, push_n};

    // arriving parcels sit right behind the stored ones so the head can bypass
    always_comb begin
        merged = {{(2*PARCEL_W){1'b0}}, buf_q};
        for (int i = 0; i < 6; i++) begin
            if (push_n != 2'd0 && i == int'(count))
                merged[PARCEL_W*i +: PARCEL_W] = push_data[PARCEL_W-1:0];
            if (push_n == 2'd2 && i == int'(count) + 1)
                merged[PARCEL_W*i +: PARCEL_W] =
                    push_data[2*PARCEL_W-1:PARCEL_W];
        end
        shifted = merged >> (PARCEL_W * int'(pop_n));
    end

    assign head = merged[2*PARCEL_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            assert ({1'b0, pop_n} <= avail &&
                    avail - {1'b0, pop_n} <= 3'd4);
            buf_q <= shifted[4*PARCEL_W-1:0];
            count <= avail - {1'b0, pop_n};
        end
    end

endmodule

// File: rtl/fetch_align.sv
// RV32IC fetch and parcel-alignment stage.
// Feeds one 16- or 32-bit instruction per cycle into the IF/ID slot.
module fetch_align
    import PipelineReg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUF_PARCELS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        kill,
    input  logic [31:0] redirect_pc,
    output ID_STATE     id_state,
    output logic        id_compressed,
    output logic        id_valid
);

    logic [31:0] fetch_addr;
    logic [31:0] issue_pc;
    logic        outstanding;
    logic        discard;
    logic        skip_low;
    logic        accept;
    logic        have;
    logic        head_rvc;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;
    logic [31:0] push_data;
    logic [31:0] head;
    logic [2:0]  count;
    logic [2:0]  avail;
    logic [2:0]  occ;

    assign accept    = outstanding & imem_rvalid;
    assign push_n    = (accept & ~discard & ~kill) ?
                       (skip_low ? 2'd1 : 2'd2) : 2'd0;
    assign push_data = skip_low ? {16'h0, imem_rdata[31:16]} : imem_rdata;
    assign avail     = count + {1'b0, push_n};
    assign head_rvc  = is_rvc(head[PARCEL_W-1:0]);
    assign have      = head_rvc ? (avail >= 3'd1) : (avail >= 3'd2);
    assign pop_n     = (~kill & ~stall & have) ?
                       (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    assign occ       = avail - {1'b0, pop_n};

    // a single word may be in flight; it must fit after this cycle's pop
    assign imem_req  = ~reset & ~kill & ~(outstanding & ~imem_rvalid) &
                       (int'(occ) + 2 <= BUF_PARCELS);
    assign imem_addr = fetch_addr;

    parcel_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (kill),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr    <= {RESET_PC[31:2], 2'b00};
            issue_pc      <= RESET_PC;
            outstanding   <= 1'b0;
            discard       <= 1'b0;
            skip_low      <= RESET_PC[1];
            id_state      <= '0;
            id_compressed <= 1'b0;
            id_valid      <= 1'b0;
        end else if (kill) begin
            fetch_addr  <= {redirect_pc[31:2], 2'b00};
            issue_pc    <= redirect_pc;
            skip_low    <= redirect_pc[1];
            outstanding <= outstanding & ~imem_rvalid;
            discard     <= outstanding & ~imem_rvalid;
            id_valid    <= 1'b0;
        end else begin
            if (!stall) begin
                id_valid <= have;
                if (have) begin
                    id_state.pc          <= issue_pc;
                    id_state.instruction <= head_rvc ?
                        {16'h0, head[15:0]} : head;
                    id_compressed        <= head_rvc;
                    issue_pc             <= issue_pc +
                        (head_rvc ? 32'd2 : 32'd4);
                end
            end
            if (accept) begin
                if (discard)
                    discard <= 1'b0;
                else
                    skip_low <= 1'b0;
            end
            outstanding <= imem_req | (outstanding & ~imem_rvalid);
            if (imem_req)
                fetch_addr <= fetch_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align with a program-order model.
// A second instance checks fetch address wrap-around.
module tb_fetch_align;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic                 imem_rvalid = 1'b0;
    logic [31:0]          imem_rdata = '0;
    logic                 stall = 1'b0;
    logic                 kill = 1'b0;
    logic [31:0]          redirect_pc = '0;
    PipelineReg::ID_STATE id_state;
    logic                 id_compressed;
    logic                 id_valid;

    logic                 req2;
    logic [31:0]          addr2;
    PipelineReg::ID_STATE st2;
    logic                 c2;
    logic                 v2;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [128];
    int          lat = 1;
    logic        pend = 1'b0;
    int          wcnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] model_pc = '0;

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .kill(kill), .redirect_pc(redirect_pc),
        .id_state(id_state), .id_compressed(id_compressed),
        .id_valid(id_valid)
    );

    fetch_align #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .stall(1'b0), .kill(1'b0), .redirect_pc(32'h0),
        .id_state(st2), .id_compressed(c2), .id_valid(v2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    function automatic logic [15:0] parcel_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[8:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // memory: single outstanding read, response lat cycles after request
    initial begin
        logic        req_s;
        logic        rst_s;
        logic [31:0] addr_s;
        forever begin
            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            rst_s  = reset;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rst_s) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    wcnt--;
                    if (wcnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem[paddr[8:2]];
                        pend        = 1'b0;
                    end
                end
                if (req_s) begin
                    paddr = addr_s;
                    wcnt  = lat - 1;
                    if (wcnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem[paddr[8:2]];
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    // program-order model: the slot must always hold the instruction at model_pc
    initial begin
        logic [15:0] p0;
        logic [31:0] ei;
        logic        ec;
        forever begin
            at_neg();
            if (reset) begin
                model_pc = 32'h0;
            end else begin
                p0 = parcel_at(model_pc);
                ec = (p0[1:0] != 2'b11);
                ei = ec ? {16'h0, p0} : {parcel_at(model_pc + 32'd2), p0};
                if (id_valid) begin
                    checks++;
                    if (id_state.pc !== model_pc ||
                        id_state.instruction !== ei ||
                        id_compressed !== ec) begin
                        errors++;
                        $display("FAIL stream: got pc %h ins %h c %b expected pc %h ins %h c %b",
                                 id_state.pc, id_state.instruction,
                                 id_compressed, model_pc, ei, ec);
                    end
                end
                if (kill)
                    model_pc = redirect_pc;
                else if (id_valid && !stall)
                    model_pc = model_pc + (ec ? 32'd2 : 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic found;
        for (int i = 0; i < 128; i++)
            mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0]    = 32'h00A0_0093;
        mem[1]    = 32'h00B0_0113;
        mem[8]    = 32'h0513_4501;
        mem[9]    = 32'h0000_4581;
        mem[8'h40] = 32'h4505_DEAD;

        repeat (3) @(posedge clk);
        at_neg();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_comp", 32'(id_compressed), 32'd0);
        chk("rst_pc", id_state.pc, 32'h0);
        chk("rst_ins", id_state.instruction, 32'h0);
        chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        chk("wrap_rst_req", 32'(req2), 32'd0);

        tick(); reset = 1'b0;
        at_neg();
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_valid", 32'(id_valid), 32'd0);
        chk("wrap_c1_req", 32'(req2), 32'd1);
        chk("wrap_c1_addr", addr2, 32'hFFFF_FFFC);
        tick(); at_neg();
        chk("c2_valid", 32'(id_valid), 32'd0);
        chk("wrap_c2_addr", addr2, 32'h0);
        chk("wrap_c2_valid", 32'(v2), 32'd0);
        tick(); at_neg();
        chk("c3_valid", 32'(id_valid), 32'd1);
        chk("c3_pc", id_state.pc, 32'h0);
        chk("c3_ins", id_state.instruction, 32'h00A0_0093);
        chk("c3_comp", 32'(id_compressed), 32'd0);
        tick(); at_neg();
        chk("c4_pc", id_state.pc, 32'h4);
        chk("c4_ins", id_state.instruction, 32'h00B0_0113);

        tick(); kill = 1'b1; redirect_pc = 32'h20;
        tick(); kill = 1'b0;
        at_neg();
        chk("k1_valid", 32'(id_valid), 32'd0);
        chk("k1_req", 32'(imem_req), 32'd1);
        chk("k1_addr", imem_addr, 32'h20);
        tick(); tick(); at_neg();
        chk("mix0_pc", id_state.pc, 32'h20);
        chk("mix0_ins", id_state.instruction, 32'h0000_4501);
        chk("mix0_comp", 32'(id_compressed), 32'd1);
        tick(); at_neg();
        chk("mix1_pc", id_state.pc, 32'h22);
        chk("mix1_ins", id_state.instruction, 32'h4581_0513);
        chk("mix1_comp", 32'(id_compressed), 32'd0);
        tick(); at_neg();
        chk("mix2_valid", 32'(id_valid), 32'd1);
        chk("mix2_pc", id_state.pc, 32'h26);
        tick(); at_neg();
        chk("mix3_pc", id_state.pc, 32'h28);

        tick(); stall = 1'b1;
        at_neg();
        chk("st0_pc", id_state.pc, 32'h2C);
        tick(); at_neg();
        chk("st1_pc", id_state.pc, 32'h2C);
        chk("st1_req", 32'(imem_req), 32'd0);
        tick(); at_neg();
        chk("st2_pc", id_state.pc, 32'h2C);
        tick(); stall = 1'b0;
        at_neg();
        chk("st3_pc", id_state.pc, 32'h2C);
        for (int i = 0; i < 3; i++) begin
            tick(); at_neg();
            chk("rel_valid", 32'(id_valid), 32'd1);
            chk("rel_pc", id_state.pc, 32'h30 + 32'(4 * i));
        end

        tick(); lat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pend) found = 1'b1;
        end
        chk("inflight_found", 32'(found), 32'd1);
        kill = 1'b1; redirect_pc = 32'h102;
        tick(); kill = 1'b0;
        at_neg();
        chk("kf1_valid", 32'(id_valid), 32'd0);
        chk("kf1_req", 32'(imem_req), 32'd1);
        chk("kf1_addr", imem_addr, 32'h100);
        tick(); at_neg();
        chk("kf2_valid", 32'(id_valid), 32'd0);
        tick(); at_neg();
        chk("kf3_valid", 32'(id_valid), 32'd0);
        tick(); at_neg();
        chk("kf4_valid", 32'(id_valid), 32'd1);
        chk("kf4_pc", id_state.pc, 32'h102);
        chk("kf4_ins", id_state.instruction, 32'h0000_4505);
        chk("kf4_comp", 32'(id_compressed), 32'd1);

        tick(); lat = 1;
        repeat (4) tick();
        stall = 1'b1; kill = 1'b1; redirect_pc = 32'h20;
        tick(); stall = 1'b0; kill = 1'b0;
        at_neg();
        chk("ks_valid", 32'(id_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(); at_neg();
            if (id_valid) found = 1'b1;
        end
        chk("ks_resume", 32'(found), 32'd1);
        chk("ks_pc", id_state.pc, 32'h20);

        repeat (3) tick();
        reset = 1'b1;
        at_neg();
        chk("mr_valid", 32'(id_valid), 32'd0);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, 32'h0);
        tick(); reset = 1'b0;
        at_neg();
        chk("mr_c1_req", 32'(imem_req), 32'd1);
        tick(); tick(); at_neg();
        chk("mr_c3_valid", 32'(id_valid), 32'd1);
        chk("mr_c3_pc", id_state.pc, 32'h0);
        repeat (6) tick();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
